// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with a valid/ready request side,
// a word-addressed byte-strobed array, and a response returned after a
// fixed number of wait cycles (LATENCY, 1..15).
// Optional feature macro: DMEM_ALIGN_CHECK_EN (misaligned access -> error).
//
// Handshakes: a request transfers on a rising edge where i_req_valid and
// o_req_ready are both 1; a response transfers on a rising edge where
// o_rsp_valid and i_rsp_ready are both 1. A valid, once raised, holds with
// its payload stable until that transfer. o_req_ready and o_rsp_valid are
// registered state decodes and never depend combinationally on the
// partner's valid/ready.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_wr_en,
  input  logic [3:0]  i_req_wstrb,
  input  logic [31:0] i_req_wr_data,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rd_data,
  output logic        o_rsp_err,
  output logic [1:0]  dbg_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  accept;
  logic                  rsp_done;
  logic                  misaligned;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [31:0]           rsp_data_q;
  logic [31:0]           mem [DEPTH];

  assign word_idx = i_req_addr[DEPTH_LOG2+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  logic rsp_err_q;
  assign misaligned = (i_req_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Upper address bits alias by design; low bits matter only with the check.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_req_addr[31:DEPTH_LOG2+2], i_req_addr[1:0]};

  assign o_req_ready   = (state_q == IDLE);
  assign o_rsp_valid   = (state_q == RESP);
  assign o_rsp_rd_data = rsp_data_q;
  assign dbg_state     = state_q;
  assign rsp_done      = (state_q == RESP) && i_rsp_ready;

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_d = RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State, counter and response payload registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      rsp_data_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        // Loads capture the pre-access word; stores and errors return zero.
        rsp_data_q <= (!i_req_wr_en && !misaligned) ? mem[word_idx] : 32'd0;
      end else if (rsp_done) begin
        rsp_data_q <= 32'd0;
      end
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  // Error flag travels with the response like the data word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_err_q <= 1'b0;
    end else if (accept) begin
      rsp_err_q <= misaligned;
    end else if (rsp_done) begin
      rsp_err_q <= 1'b0;
    end
  end
  assign o_rsp_err = rsp_err_q;
`else
  assign o_rsp_err = 1'b0;
`endif

  // Byte-lane store into the array; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (!rst && accept && i_req_wr_en && !misaligned) begin
      for (int k = 0; k < 4; k++) begin
        if (i_req_wstrb[k]) begin
          mem[word_idx][8*k +: 8] <= i_req_wr_data[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder (LATENCY=2, DEPTH_LOG2=10): table of
// load/store vectors plus hand sequences for backpressure and reset.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic        i_req_wr_en;
  logic [3:0]  i_req_wstrb;
  logic [31:0] i_req_wr_data;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rd_data;
  logic        o_rsp_err;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(LAT)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_addr    (i_req_addr),
    .i_req_wr_en   (i_req_wr_en),
    .i_req_wstrb   (i_req_wstrb),
    .i_req_wr_data (i_req_wr_data),
    .o_rsp_valid   (o_rsp_valid),
    .i_rsp_ready   (i_rsp_ready),
    .o_rsp_rd_data (o_rsp_rd_data),
    .o_rsp_err     (o_rsp_err),
    .dbg_state     (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one request from IDLE, waits for the response and completes it.
  // Inputs change #1 after rising edges.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat);
    i_req_valid   = 1'b1;
    i_req_wr_en   = wr;
    i_req_addr    = addr;
    i_req_wstrb   = strb;
    i_req_wr_data = wdata;
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    lat = 1;
    while (!o_rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!o_rsp_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout: no response after %0d cycles", lat);
    end
    rdata = o_rsp_rd_data;
    err   = o_rsp_err;
    i_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    i_rsp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    // Reset block
    rst = 1'b1;
    i_req_valid = 1'b0;
    i_req_addr = '0;
    i_req_wr_en = 1'b0;
    i_req_wstrb = '0;
    i_req_wr_data = '0;
    i_rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("reset_req_ready", {31'd0, o_req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("reset_rd_data", o_rsp_rd_data, 32'd0);
    chk("reset_err", {31'd0, o_rsp_err}, 32'd0);

    //            wr    addr          strb  wdata         exp_data      err
    vecs[0]  = '{1'b1, 32'h0000_0040, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0040, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0040, 4'h1, 32'h000000AA, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0040, 4'h0, 32'h0,        32'hDEADBEAA, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0040, 4'h0, 32'hFFFFFFFF, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0040, 4'h0, 32'h0,        32'hDEADBEAA, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_1000, 4'hF, 32'h12345678, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 32'h0000_0000, 4'h0, 32'h0,        32'h12345678, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0044, 4'hF, 32'h00000000, 32'h0,        1'b0};
    vecs[9]  = '{1'b1, 32'h0000_0044, 4'h6, 32'hAABBCCDD, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 32'h0000_0044, 4'h0, 32'h0,        32'h00BBCC00, 1'b0};
    vecs[11] = '{1'b0, 32'hFFFF_F044, 4'h0, 32'h0,        32'h00BBCC00, 1'b0};

    for (int i = 0; i < 12; i++) begin
      chk($sformatf("v%0d_req_ready", i), {31'd0, o_req_ready}, 32'd1);
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].strb, vecs[i].wdata, rd, er, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(LAT));
      chk($sformatf("v%0d_rd_data", i), rd, vecs[i].exp_data);
      chk($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
    end
    chk("post_table_req_ready", {31'd0, o_req_ready}, 32'd1);

    // Backpressure: response held 5 cycles, competing store must not enter.
    i_req_valid = 1'b1;
    i_req_wr_en = 1'b0;
    i_req_addr  = 32'h40;
    @(posedge clk);
    #1;
    i_req_wr_en   = 1'b1;
    i_req_wstrb   = 4'hF;
    i_req_wr_data = 32'h0;
    lat = 1;
    while (!o_rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp_latency", 32'(lat), 32'(LAT));
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_rsp_valid", c), {31'd0, o_rsp_valid}, 32'd1);
      chk($sformatf("bp%0d_rd_data", c), o_rsp_rd_data, 32'hDEADBEAA);
      chk($sformatf("bp%0d_req_ready", c), {31'd0, o_req_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    i_rsp_ready = 1'b0;
    chk("bp_after_req_ready", {31'd0, o_req_ready}, 32'd1);
    chk("bp_after_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    do_req(1'b0, 32'h40, 4'h0, 32'h0, rd, er, lat);
    chk("bp_store_ignored", rd, 32'hDEADBEAA);

    // Reset one cycle into WAIT drops the pending load.
    i_req_valid = 1'b1;
    i_req_wr_en = 1'b0;
    i_req_addr  = 32'h0;
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_wait_req_ready", {31'd0, o_req_ready}, 32'd1);
    chk("rst_wait_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("rst_wait_rd_data", o_rsp_rd_data, 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_wait_no_rsp", {31'd0, o_rsp_valid}, 32'd0);
    end
    do_req(1'b0, 32'h0, 4'h0, 32'h0, rd, er, lat);
    chk("rst_fresh_load_latency", 32'(lat), 32'(LAT));
    chk("rst_fresh_load_data", rd, 32'h12345678);

    // Reset and request on the same edge: neither request nor write lands.
    rst = 1'b1;
    i_req_valid   = 1'b1;
    i_req_wr_en   = 1'b1;
    i_req_addr    = 32'h40;
    i_req_wstrb   = 4'hF;
    i_req_wr_data = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    i_req_valid = 1'b0;
    chk("rst_req_req_ready", {31'd0, o_req_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("rst_req_no_rsp", {31'd0, o_rsp_valid}, 32'd0);
    do_req(1'b0, 32'h40, 4'h0, 32'h0, rd, er, lat);
    chk("rst_req_no_write", rd, 32'hDEADBEAA);

`ifdef DMEM_ALIGN_CHECK_EN
    do_req(1'b1, 32'h42, 4'hF, 32'hFFFFFFFF, rd, er, lat);
    chk("align_st_latency", 32'(lat), 32'(LAT));
    chk("align_st_err", {31'd0, er}, 32'd1);
    chk("align_st_data", rd, 32'd0);
    do_req(1'b0, 32'h40, 4'h0, 32'h0, rd, er, lat);
    chk("align_ld_err", {31'd0, er}, 32'd0);
    chk("align_ld_data", rd, 32'hDEADBEAA);
    do_req(1'b0, 32'h41, 4'h0, 32'h0, rd, er, lat);
    chk("align_misld_err", {31'd0, er}, 32'd1);
    chk("align_misld_data", rd, 32'd0);
`else
    do_req(1'b1, 32'h46, 4'h1, 32'h00000055, rd, er, lat);
    chk("noalign_st_err", {31'd0, er}, 32'd0);
    do_req(1'b0, 32'h47, 4'h0, 32'h0, rd, er, lat);
    chk("noalign_ld_err", {31'd0, er}, 32'd0);
    chk("noalign_ld_data", rd, 32'h00BBCC55);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
